// File: rtl/mplc_wr_sequencer.sv
// Per-core write capture and serialiser onto the shared-memory write port.
// Optional aging override: define MPLC_WR_AGING_EN.
module mplc_wr_sequencer #(
  parameter int DATA_W  = 2,
  parameter int ADDR_W  = 1,
  parameter int AGE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              req_2,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  output logic              ack_0,
  output logic              ack_1,
  output logic              ack_2,
  output logic              we_0,
  output logic              we_1,
  output logic              we_2,
  input  logic              wt_0,
  input  logic              wt_1,
  input  logic              wt_2,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DONE
  } slot_e;

  slot_e             st_q [3];
  slot_e             st_d [3];
  logic [ADDR_W-1:0] addr_q [3];
  logic [DATA_W-1:0] data_q [3];
  logic [ADDR_W-1:0] addr_in [3];
  logic [DATA_W-1:0] data_in [3];
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [2:0]        req;
  logic [2:0]        wt;
  logic [2:0]        pend;
  logic [2:0]        done;
  logic [2:0]        we;
  logic [2:0]        gnt;
  logic [2:0]        win;

  assign req = {req_2, req_1, req_0};
  assign wt  = {wt_2, wt_1, wt_0};
  assign addr_in[0] = addr_0;
  assign addr_in[1] = addr_1;
  assign addr_in[2] = addr_2;
  assign data_in[0] = data_0;
  assign data_in[1] = data_1;
  assign data_in[2] = data_2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = (st_q[i] == PEND);
      done[i] = (st_q[i] == DONE);
    end
  end

`ifdef MPLC_WR_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0] age_q [3];
  logic [2:0]       aged;
  logic [2:0]       mask;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      aged[i] = (age_q[i] == AGE_W'(AGE_MAX));
    end
  end

  // lowest aged slot becomes the only visible requester
  assign mask = aged & (~aged + 3'd1);
  assign we   = (|aged) ? mask : pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] || win[i]) age_q[i] <= '0;
        else if (!aged[i]) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`else
  assign we = pend;

  // AGE_MAX only matters with aging enabled
  if (AGE_MAX < 1) begin : g_age_unused
  end
`endif

  // arbiter should grant one slot; extras stay pending
  assign gnt = we & wt;
  assign win = gnt & (~gnt + 3'd1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (1'b1)
      win[0]: begin
        sel_addr = addr_q[0];
        sel_data = data_q[0];
      end
      win[1]: begin
        sel_addr = addr_q[1];
        sel_data = data_q[1];
      end
      win[2]: begin
        sel_addr = addr_q[2];
        sel_data = data_q[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        IDLE:    if (req[i]) st_d[i] = PEND;
        PEND:    if (win[i]) st_d[i] = DONE;
        DONE:    st_d[i] = IDLE;
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]   <= IDLE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      err      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i] <= st_d[i];
        if (st_q[i] == IDLE && req[i]) begin
          addr_q[i] <= addr_in[i];
          data_q[i] <= data_in[i];
        end
      end
      mem_we <= |win;
      if (|win) begin
        mem_addr <= sel_addr;
        mem_data <= sel_data;
      end
      if (gnt != win) err <= 1'b1;
    end
  end

  assign {we_2, we_1, we_0}    = we;
  assign {ack_2, ack_1, ack_0} = done;
  assign busy = |pend;

endmodule
